// File: rtl/regfile_port_scheduler_pkg.sv
// Shared constants and types for the register-file write-port scheduler.
package regfile_pkg;
  localparam int unsigned WIDTH            = 16;
  localparam int unsigned REGISTER_BITS    = 4;
  localparam int unsigned DBG_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    SRC_CLEAR = 2'd0,
    SRC_ALU   = 2'd1,
    SRC_MEM   = 2'd2,
    SRC_DBG   = 2'd3
  } write_src_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  typedef enum logic {
    RR_ALU = 1'b0,
    RR_MEM = 1'b1
  } rr_sel_t;
endpackage

// File: rtl/regfile_port_scheduler_if.sv
// Requester handshakes and register-file write drive of the port scheduler.
interface regfile_port_scheduler_if #(
  parameter int unsigned WIDTH         = regfile_pkg::WIDTH,
  parameter int unsigned REGISTER_BITS = regfile_pkg::REGISTER_BITS
);
  logic                     alu_valid;
  logic [REGISTER_BITS-1:0] alu_addr;
  logic [WIDTH-1:0]         alu_data;
  logic                     alu_ready;
  logic                     mem_valid;
  logic [REGISTER_BITS-1:0] mem_addr;
  logic [WIDTH-1:0]         mem_data;
  logic                     mem_ready;
  logic                     dbg_valid;
  logic [REGISTER_BITS-1:0] dbg_addr;
  logic [WIDTH-1:0]         dbg_data;
  logic                     dbg_ready;
  logic                     rf_write;
  logic [REGISTER_BITS-1:0] rf_waddr;
  logic [WIDTH-1:0]         rf_wdata;
  logic [1:0]               write_src;

  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           dbg_valid, dbg_addr, dbg_data,
    input  alu_ready, mem_ready, dbg_ready, rf_write, rf_waddr, rf_wdata, write_src
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           dbg_valid, dbg_addr, dbg_data,
    output alu_ready, mem_ready, dbg_ready, rf_write, rf_waddr, rf_wdata, write_src
  );
endinterface

// File: rtl/rf_rr_arbiter.sv
// Two-way round-robin between ALU and load-unit writebacks.
module rf_rr_arbiter
  import regfile_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    alu_valid,
  input  logic    mem_valid,
  input  logic    accept,
  output rr_sel_t grant
);
  rr_sel_t last;

  // Reset to "mem granted last" so the ALU wins the first tie.
  always_ff @(posedge clock) begin
    if (!reset)      last <= RR_MEM;
    else if (accept) last <= grant;
  end

  always_comb begin
    grant = RR_ALU;
    if (alu_valid && mem_valid) grant = (last == RR_MEM) ? RR_ALU : RR_MEM;
    else if (mem_valid)         grant = RR_MEM;
  end
endmodule

// File: rtl/regfile_port_scheduler.sv
// Single register-file write port shared by ALU, load unit and debug host,
// with a clearing sweep of registers 1..N after reset or on request.
module regfile_port_scheduler
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH         = regfile_pkg::WIDTH,
  parameter int unsigned REGISTER_BITS = regfile_pkg::REGISTER_BITS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear_req,
  regfile_port_scheduler_if.slave  rf,
  output logic                     busy
);
  localparam logic [REGISTER_BITS-1:0] FIRST_ADDR = {{(REGISTER_BITS-1){1'b0}}, 1'b1};
  localparam logic [REGISTER_BITS-1:0] LAST_ADDR  = '1;

  state_t                   state, state_nx;
  logic [REGISTER_BITS-1:0] clr_addr, clr_addr_nx;
  logic [3:0]               dbg_wait, dbg_wait_nx;
  logic                     wr_q, wr_nx;
  logic [REGISTER_BITS-1:0] waddr_q, waddr_nx;
  logic [WIDTH-1:0]         wdata_q, wdata_nx;
  write_src_t               src_q, src_nx;

  rr_sel_t rr_grant;
  logic    acc_alu, acc_mem, acc_dbg;
  logic    run_ok, dbg_starved;

  assign run_ok      = reset && (state == ST_RUN) && !clear_req;
  assign dbg_starved = (dbg_wait >= 4'(DBG_STARVE_LIMIT));

  rf_rr_arbiter u_rr (
    .clock    (clock),
    .reset    (reset),
    .alu_valid(rf.alu_valid),
    .mem_valid(rf.mem_valid),
    .accept   (acc_alu || acc_mem),
    .grant    (rr_grant)
  );

  // A starved debug host overrides the ALU/load round-robin.
  always_comb begin
    acc_alu = 1'b0;
    acc_mem = 1'b0;
    acc_dbg = 1'b0;
    if (run_ok) begin
      if (rf.dbg_valid && dbg_starved) begin
        acc_dbg = 1'b1;
      end else if (rf.alu_valid || rf.mem_valid) begin
        acc_alu = (rr_grant == RR_ALU);
        acc_mem = (rr_grant == RR_MEM);
      end else begin
        acc_dbg = rf.dbg_valid;
      end
    end
  end

  assign rf.alu_ready = acc_alu;
  assign rf.mem_ready = acc_mem;
  assign rf.dbg_ready = acc_dbg;
  assign busy         = !reset || (state == ST_CLEAR);

  always_comb begin
    state_nx    = state;
    clr_addr_nx = clr_addr;
    wr_nx       = 1'b0;
    waddr_nx    = waddr_q;
    wdata_nx    = wdata_q;
    src_nx      = src_q;
    dbg_wait_nx = dbg_wait;

    case (state)
      ST_CLEAR: begin
        wr_nx    = 1'b1;
        waddr_nx = clr_addr;
        wdata_nx = '0;
        src_nx   = SRC_CLEAR;
        if (clear_req) begin
          clr_addr_nx = FIRST_ADDR;
        end else if (clr_addr == LAST_ADDR) begin
          state_nx    = ST_RUN;
          clr_addr_nx = FIRST_ADDR;
        end else begin
          clr_addr_nx = clr_addr + 1'b1;
        end
      end
      default: begin
        if (clear_req) begin
          state_nx    = ST_CLEAR;
          clr_addr_nx = FIRST_ADDR;
        end
        // Writes to register 0 complete the handshake but are dropped here.
        if (acc_alu) begin
          wr_nx = |rf.alu_addr; waddr_nx = rf.alu_addr; wdata_nx = rf.alu_data; src_nx = SRC_ALU;
        end else if (acc_mem) begin
          wr_nx = |rf.mem_addr; waddr_nx = rf.mem_addr; wdata_nx = rf.mem_data; src_nx = SRC_MEM;
        end else if (acc_dbg) begin
          wr_nx = |rf.dbg_addr; waddr_nx = rf.dbg_addr; wdata_nx = rf.dbg_data; src_nx = SRC_DBG;
        end
      end
    endcase

    if (!rf.dbg_valid || acc_dbg)                  dbg_wait_nx = '0;
    else if (state == ST_RUN && dbg_wait != '1)    dbg_wait_nx = dbg_wait + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_CLEAR;
      clr_addr <= FIRST_ADDR;
      dbg_wait <= '0;
      wr_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      src_q    <= SRC_CLEAR;
    end else begin
      state    <= state_nx;
      clr_addr <= clr_addr_nx;
      dbg_wait <= dbg_wait_nx;
      wr_q     <= wr_nx;
      waddr_q  <= waddr_nx;
      wdata_q  <= wdata_nx;
      src_q    <= src_nx;
    end
  end

  assign rf.rf_write  = wr_q;
  assign rf.rf_waddr  = waddr_q;
  assign rf.rf_wdata  = wdata_q;
  assign rf.write_src = src_q;
endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Self-checking bench: directed vector table, corner sequences, and random traffic
// checked every cycle against a behavioural scheduler model.
module tb_regfile_port_scheduler;
  localparam int W  = 16;
  localparam int RB = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clear_req = 1'b0;
  logic busy;

  regfile_port_scheduler_if #(.WIDTH(W), .REGISTER_BITS(RB)) rf ();

  regfile_port_scheduler #(.WIDTH(W), .REGISTER_BITS(RB)) dut (
    .clock    (clock),
    .reset    (reset),
    .clear_req(clear_req),
    .rf       (rf),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  int nvec  = 0;
  int nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Behavioural model: m_sweep is the next register to clear (0 once running),
  // grants are 0 none, 1 alu, 2 mem, 3 dbg.
  int m_sweep = 1, m_last_mem = 1, m_starve = 0;
  int m_wr = 0, m_waddr = 0, m_wdata = 0, m_src = 0;
  int last_g = 0;

  function automatic int pred_grant();
    if (reset !== 1'b1 || m_sweep != 0 || clear_req) return 0;
    if (rf.dbg_valid && m_starve >= 8) return 3;
    if (rf.alu_valid && rf.mem_valid) return m_last_mem ? 1 : 2;
    if (rf.alu_valid) return 1;
    if (rf.mem_valid) return 2;
    if (rf.dbg_valid) return 3;
    return 0;
  endfunction

  always @(negedge clock) begin
    int pg;
    pg = pred_grant();
    check("model_alu_ready", 32'(rf.alu_ready), 32'(pg == 1));
    check("model_mem_ready", 32'(rf.mem_ready), 32'(pg == 2));
    check("model_dbg_ready", 32'(rf.dbg_ready), 32'(pg == 3));
    check("model_busy", 32'(busy), 32'(reset !== 1'b1 || m_sweep != 0));
  end

  always @(posedge clock) begin
    int g;
    g = pred_grant();
    if (reset !== 1'b1) begin
      m_sweep = 1; m_last_mem = 1; m_starve = 0;
      m_wr = 0; m_waddr = 0; m_wdata = 0; m_src = 0; g = 0;
    end else if (m_sweep != 0) begin
      m_wr = 1; m_waddr = m_sweep; m_wdata = 0; m_src = 0;
      if (clear_req)          m_sweep = 1;
      else if (m_sweep == 15) m_sweep = 0;
      else                    m_sweep++;
      if (!rf.dbg_valid) m_starve = 0;
    end else begin
      m_wr = 0;
      case (g)
        1: begin m_wr = int'(rf.alu_addr != 0); m_waddr = int'(rf.alu_addr); m_wdata = int'(rf.alu_data); m_src = 1; m_last_mem = 0; end
        2: begin m_wr = int'(rf.mem_addr != 0); m_waddr = int'(rf.mem_addr); m_wdata = int'(rf.mem_data); m_src = 2; m_last_mem = 1; end
        3: begin m_wr = int'(rf.dbg_addr != 0); m_waddr = int'(rf.dbg_addr); m_wdata = int'(rf.dbg_data); m_src = 3; end
        default: ;
      endcase
      if (!rf.dbg_valid || g == 3) m_starve = 0;
      else if (m_starve < 15)      m_starve++;
      if (clear_req) m_sweep = 1;
    end
    last_g = g;
    #1;
    check("model_rf_write", 32'(rf.rf_write), m_wr);
    check("model_rf_waddr", 32'(rf.rf_waddr), m_waddr);
    check("model_rf_wdata", 32'(rf.rf_wdata), m_wdata);
    check("model_write_src", 32'(rf.write_src), m_src);
  end

  typedef struct {
    bit clr;
    bit av; int aa; int ad;
    bit mv; int ma; int md;
    bit dv; int da; int dd;
    int rdy; bit wr; int waddr; int wdata; int src;
  } vec_t;

  vec_t tbl[8];
  int   wait_n, cnt;

  initial begin
    rf.alu_valid = 1'b0; rf.alu_addr = '0; rf.alu_data = '0;
    rf.mem_valid = 1'b0; rf.mem_addr = '0; rf.mem_data = '0;
    rf.dbg_valid = 1'b0; rf.dbg_addr = '0; rf.dbg_data = '0;

    //         clr av aa ad       mv ma md       dv da dd        rdy wr waddr wdata   src
    tbl[0] = '{0, 1, 3, 'h1111, 1, 5, 'h2222, 0, 0, 0,       1, 1, 3, 'h1111, 1};
    tbl[1] = '{0, 1, 3, 'h1111, 1, 5, 'h2222, 0, 0, 0,       2, 1, 5, 'h2222, 2};
    tbl[2] = '{0, 1, 3, 'h1111, 1, 5, 'h2222, 0, 0, 0,       1, 1, 3, 'h1111, 1};
    tbl[3] = '{0, 0, 0, 0,      0, 0, 0,      0, 0, 0,       0, 0, 0, 0,      0};
    tbl[4] = '{0, 0, 0, 0,      0, 0, 0,      1, 9, 'h0D0D,  3, 1, 9, 'h0D0D, 3};
    tbl[5] = '{0, 0, 0, 0,      1, 2, 'h0042, 0, 0, 0,       2, 1, 2, 'h0042, 2};
    tbl[6] = '{0, 1, 0, 'hBEEF, 0, 0, 0,      0, 0, 0,       1, 0, 0, 0,      0};
    tbl[7] = '{0, 1, 4, 'h0A0A, 1, 6, 'h0B0B, 0, 0, 0,       2, 1, 6, 'h0B0B, 2};

    // Reset, then the 15-cycle clearing sweep.
    repeat (3) tick();
    reset = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("sweep_write", 32'(rf.rf_write), 1);
      check("sweep_addr", 32'(rf.rf_waddr), k);
      check("sweep_data", 32'(rf.rf_wdata), 0);
      check("sweep_busy", 32'(busy), 32'(k < 15));
    end

    // Directed arbitration table.
    for (int i = 0; i < 8; i++) begin
      clear_req    = tbl[i].clr;
      rf.alu_valid = tbl[i].av; rf.alu_addr = 4'(tbl[i].aa); rf.alu_data = 16'(tbl[i].ad);
      rf.mem_valid = tbl[i].mv; rf.mem_addr = 4'(tbl[i].ma); rf.mem_data = 16'(tbl[i].md);
      rf.dbg_valid = tbl[i].dv; rf.dbg_addr = 4'(tbl[i].da); rf.dbg_data = 16'(tbl[i].dd);
      #3;
      check("tbl_alu_ready", 32'(rf.alu_ready), 32'(tbl[i].rdy == 1));
      check("tbl_mem_ready", 32'(rf.mem_ready), 32'(tbl[i].rdy == 2));
      check("tbl_dbg_ready", 32'(rf.dbg_ready), 32'(tbl[i].rdy == 3));
      tick();
      check("tbl_rf_write", 32'(rf.rf_write), 32'(tbl[i].wr));
      if (tbl[i].wr) begin
        check("tbl_rf_waddr", 32'(rf.rf_waddr), tbl[i].waddr);
        check("tbl_rf_wdata", 32'(rf.rf_wdata), tbl[i].wdata);
        check("tbl_write_src", 32'(rf.write_src), tbl[i].src);
      end
    end

    // Debug starvation under saturating alu/mem traffic.
    rf.alu_valid = 1'b1; rf.alu_addr = 4'd3;  rf.alu_data = 16'h1111;
    rf.mem_valid = 1'b1; rf.mem_addr = 4'd5;  rf.mem_data = 16'h2222;
    rf.dbg_valid = 1'b1; rf.dbg_addr = 4'd10; rf.dbg_data = 16'hD00D;
    wait_n = -1;
    for (int i = 0; i < 20 && wait_n < 0; i++) begin
      #3;
      if (rf.dbg_ready === 1'b1) wait_n = i;
      tick();
    end
    check("dbg_wait_cycles", wait_n, 8);
    check("dbg_write_src", 32'(rf.write_src), 3);
    check("dbg_waddr", 32'(rf.rf_waddr), 10);
    check("dbg_wdata", 32'(rf.rf_wdata), 32'h0000D00D);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      #3;
      if (rf.dbg_ready === 1'b1) cnt++;
      tick();
    end
    check("dbg_single_grant", cnt, 0);
    rf.alu_valid = 1'b0; rf.mem_valid = 1'b0; rf.dbg_valid = 1'b0;
    tick();

    // clear_req from RUN, then again at sweep address 7.
    rf.alu_valid = 1'b1; rf.alu_addr = 4'd7; rf.alu_data = 16'h7777;
    clear_req = 1'b1;
    #3;
    check("clr_alu_blocked", 32'(rf.alu_ready), 0);
    tick();
    clear_req = 1'b0;
    check("clr_entry_write", 32'(rf.rf_write), 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("clr_first_addr", 32'(rf.rf_waddr), k);
    end
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clr_restart_addr7", 32'(rf.rf_waddr), 7);
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("clr_resweep_addr", 32'(rf.rf_waddr), k);
      check("clr_resweep_write", 32'(rf.rf_write), 1);
      check("clr_resweep_busy", 32'(busy), 32'(k < 15));
    end
    #3;
    check("alu_after_sweep", 32'(rf.alu_ready), 1);
    tick();
    rf.alu_valid = 1'b0;

    // Reset pulsed mid-RUN with mem_valid held.
    rf.mem_valid = 1'b1; rf.mem_addr = 4'd5; rf.mem_data = 16'h5555;
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #3;
      check("rst_mem_ready", 32'(rf.mem_ready), 0);
      check("rst_busy", 32'(busy), 1);
      tick();
    end
    reset = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      #3;
      check("rst_sweep_mem_ready", 32'(rf.mem_ready), 0);
      tick();
      check("rst_sweep_addr", 32'(rf.rf_waddr), k);
    end
    #3;
    check("rst_mem_ready_after", 32'(rf.mem_ready), 1);
    tick();
    rf.mem_valid = 1'b0;

    // Random traffic; requests are held until the model sees them accepted.
    for (int c = 0; c < 3000; c++) begin
      if (!rf.alu_valid || last_g == 1) begin
        rf.alu_valid = ($urandom_range(0, 99) < 60);
        rf.alu_addr  = 4'($urandom_range(0, 15));
        rf.alu_data  = 16'($urandom);
      end
      if (!rf.mem_valid || last_g == 2) begin
        rf.mem_valid = ($urandom_range(0, 99) < 60);
        rf.mem_addr  = 4'($urandom_range(0, 15));
        rf.mem_data  = 16'($urandom);
      end
      if (!rf.dbg_valid || last_g == 3) begin
        rf.dbg_valid = ($urandom_range(0, 99) < 30);
        rf.dbg_addr  = 4'($urandom_range(0, 15));
        rf.dbg_data  = 16'($urandom);
      end
      clear_req = ($urandom_range(0, 99) == 0);
      reset     = ($urandom_range(0, 299) != 0);
      tick();
    end
    rf.alu_valid = 1'b0; rf.mem_valid = 1'b0; rf.dbg_valid = 1'b0;
    clear_req = 1'b0; reset = 1'b1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
